// File: rtl/audio_synth_n.sv
// N-channel programmable sound generator: wide dividers, noise, gated notes
// with duration and linear decay, summed into a single PWM audio bit.
module audio_synth_n #(
    parameter int NUM_CH    = 4,
    parameter int DIV_W     = 12,
    parameter int VOL_W     = 4,
    parameter int PRESCALE  = 56,
    parameter int FRAME_DIV = 1792,
    parameter int ADDR_W    = $clog2(4*NUM_CH+1),
    parameter int MIX_W     = VOL_W + $clog2(NUM_CH)
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              wr_en,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] addr,
    input  logic [15:0]       wdata,
    output logic [15:0]       rdata,
    output logic              aud,
    output logic [NUM_CH-1:0] active,
    output logic [NUM_CH-1:0] done
);

    localparam int PS_W = $clog2(PRESCALE);
    localparam int FR_W = $clog2(FRAME_DIV);

    logic [PS_W-1:0]  presc_q, presc_d;
    logic [FR_W-1:0]  frm_q, frm_d;
    logic [16:0]      lfsr_q, lfsr_d;
    logic [MIX_W-1:0] pwm_q, pwm_d;
    logic [MIX_W-1:0] mix;
    logic [15:0]      rdata_q, rdata_d;
    logic             aud_q, aud_d;
    logic             tick, frame;

    logic [DIV_W-1:0] div_q [NUM_CH];
    logic [DIV_W-1:0] div_d [NUM_CH];
    logic [DIV_W-1:0] cnt_q [NUM_CH];
    logic [DIV_W-1:0] cnt_d [NUM_CH];
    logic [VOL_W-1:0] vol_q [NUM_CH];
    logic [VOL_W-1:0] vol_d [NUM_CH];
    logic [VOL_W-1:0] cur_vol_q [NUM_CH];
    logic [VOL_W-1:0] cur_vol_d [NUM_CH];
    logic [1:0]       mode_q [NUM_CH];
    logic [1:0]       mode_d [NUM_CH];
    logic [15:0]      dur_q [NUM_CH];
    logic [15:0]      dur_d [NUM_CH];
    logic [15:0]      dur_cnt_q [NUM_CH];
    logic [15:0]      dur_cnt_d [NUM_CH];

    logic [NUM_CH-1:0] env_q, env_d;
    logic [NUM_CH-1:0] tone_q, tone_d;
    logic [NUM_CH-1:0] samp_q, samp_d;
    logic [NUM_CH-1:0] active_q, active_d;
    logic [NUM_CH-1:0] done_q, done_d;
    logic [NUM_CH-1:0] wave;

    assign tick  = (presc_q == PS_W'(PRESCALE-1));
    assign frame = tick && (frm_q == FR_W'(FRAME_DIV-1));

    always_comb begin
        presc_d = tick ? '0 : presc_q + PS_W'(1);
        frm_d   = frm_q;
        if (tick) begin
            frm_d = frame ? '0 : frm_q + FR_W'(1);
        end
        lfsr_d = lfsr_q;
        if (tick) begin
            lfsr_d = {lfsr_q[15:0], ~(lfsr_q[16] ^ lfsr_q[11])};
        end
        pwm_d = pwm_q + MIX_W'(1);
    end

    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            div_d[c]     = div_q[c];
            cnt_d[c]     = cnt_q[c];
            vol_d[c]     = vol_q[c];
            cur_vol_d[c] = cur_vol_q[c];
            mode_d[c]    = mode_q[c];
            dur_d[c]     = dur_q[c];
            dur_cnt_d[c] = dur_cnt_q[c];
            env_d[c]     = env_q[c];
            tone_d[c]    = tone_q[c];
            samp_d[c]    = samp_q[c];
            active_d[c]  = active_q[c];
            done_d[c]    = 1'b0;

            if (wr_en && addr == ADDR_W'(4*c)) begin
                div_d[c] = wdata[DIV_W-1:0];
            end
            if (wr_en && addr == ADDR_W'(4*c+1)) begin
                vol_d[c]  = wdata[VOL_W-1:0];
                mode_d[c] = wdata[9:8];
                env_d[c]  = wdata[10];
            end
            if (wr_en && addr == ADDR_W'(4*c+2)) begin
                dur_d[c] = wdata;
            end

            // >= compare lets a DIV shrunk below cnt wrap on the next tick
            if (tick) begin
                if (cnt_q[c] >= div_q[c]) begin
                    cnt_d[c]  = '0;
                    tone_d[c] = ~tone_q[c];
                    if (!tone_q[c]) begin
                        samp_d[c] = lfsr_q[16];
                    end
                end else begin
                    cnt_d[c] = cnt_q[c] + DIV_W'(1);
                end
            end

            if (frame && active_q[c]) begin
                if (env_q[c] && cur_vol_q[c] != '0) begin
                    cur_vol_d[c] = cur_vol_q[c] - VOL_W'(1);
                end
                if (dur_cnt_q[c] != 16'd0) begin
                    dur_cnt_d[c] = dur_cnt_q[c] - 16'd1;
                    if (dur_cnt_q[c] == 16'd1) begin
                        active_d[c] = 1'b0;
                        done_d[c]   = 1'b1;
                    end
                end
            end

            if (!env_d[c]) begin
                cur_vol_d[c] = vol_d[c];
            end

            // a gate landing on an expiring frame restarts the note
            if (wr_en && addr == ADDR_W'(4*c+1) && wdata[15]) begin
                active_d[c]  = 1'b1;
                cur_vol_d[c] = wdata[VOL_W-1:0];
                dur_cnt_d[c] = dur_q[c];
                done_d[c]    = 1'b0;
            end
        end
    end

    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            case (mode_q[c])
                2'b00:   wave[c] = tone_q[c];
                2'b01:   wave[c] = tone_q[c] & samp_q[c];
                2'b10:   wave[c] = 1'b1;
                default: wave[c] = 1'b0;
            endcase
        end
    end

    always_comb begin
        mix = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (active_q[c] && wave[c]) begin
                mix = mix + MIX_W'(cur_vol_q[c]);
            end
        end
        aud_d = (pwm_q < mix);
    end

    always_comb begin
        rdata_d = rdata_q;
        if (rd_en) begin
            rdata_d = '0;
            for (int c = 0; c < NUM_CH; c++) begin
                if (addr == ADDR_W'(4*c)) begin
                    rdata_d = 16'(div_q[c]);
                end
                if (addr == ADDR_W'(4*c+1)) begin
                    rdata_d[VOL_W-1:0] = vol_q[c];
                    rdata_d[9:8]       = mode_q[c];
                    rdata_d[10]        = env_q[c];
                end
                if (addr == ADDR_W'(4*c+2)) begin
                    rdata_d = dur_q[c];
                end
                if (addr == ADDR_W'(4*c+3)) begin
                    rdata_d[VOL_W-1:0] = cur_vol_q[c];
                    rdata_d[8]         = active_q[c];
                    rdata_d[9]         = wave[c];
                end
            end
            if (addr == ADDR_W'(4*NUM_CH)) begin
                rdata_d = {8'd0, lfsr_q[16:9]};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            presc_q  <= '0;
            frm_q    <= '0;
            lfsr_q   <= '0;
            pwm_q    <= '0;
            rdata_q  <= '0;
            aud_q    <= 1'b0;
            env_q    <= '0;
            tone_q   <= '0;
            samp_q   <= '0;
            active_q <= '0;
            done_q   <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
                div_q[c]     <= '0;
                cnt_q[c]     <= '0;
                vol_q[c]     <= '0;
                cur_vol_q[c] <= '0;
                mode_q[c]    <= '0;
                dur_q[c]     <= '0;
                dur_cnt_q[c] <= '0;
            end
        end else begin
            presc_q  <= presc_d;
            frm_q    <= frm_d;
            lfsr_q   <= lfsr_d;
            pwm_q    <= pwm_d;
            rdata_q  <= rdata_d;
            aud_q    <= aud_d;
            env_q    <= env_d;
            tone_q   <= tone_d;
            samp_q   <= samp_d;
            active_q <= active_d;
            done_q   <= done_d;
            for (int c = 0; c < NUM_CH; c++) begin
                div_q[c]     <= div_d[c];
                cnt_q[c]     <= cnt_d[c];
                vol_q[c]     <= vol_d[c];
                cur_vol_q[c] <= cur_vol_d[c];
                mode_q[c]    <= mode_d[c];
                dur_q[c]     <= dur_d[c];
                dur_cnt_q[c] <= dur_cnt_d[c];
            end
        end
    end

    assign rdata  = rdata_q;
    assign aud    = aud_q;
    assign active = active_q;
    assign done   = done_q;

endmodule

// File: tb/tb_audio_synth_n.sv
// Directed bench for audio_synth_n with PRESCALE=4, FRAME_DIV=8, four channels:
// one frame every 32 clk, PWM period 64 clk.
module tb_audio_synth_n;

    localparam int NUM_CH = 4;
    localparam int AW     = 5;

    logic          clk;
    logic          clr;
    logic          wr_en;
    logic          rd_en;
    logic [AW-1:0] addr;
    logic [15:0]   wdata;
    logic [15:0]   rdata;
    logic          aud;
    logic [3:0]    active;
    logic [3:0]    done;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    audio_synth_n #(
        .NUM_CH(NUM_CH), .DIV_W(12), .VOL_W(4),
        .PRESCALE(4), .FRAME_DIV(8)
    ) dut (
        .clk(clk), .clr(clr), .wr_en(wr_en), .rd_en(rd_en),
        .addr(addr), .wdata(wdata), .rdata(rdata), .aud(aud),
        .active(active), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // cyc = number of posedges since clr was released
    always @(posedge clk) begin
        if (clr) cyc = 0;
        else     cyc = cyc + 1;
    end

    task automatic do_reset();
        clr = 1'b1;
        repeat (2) @(negedge clk);
        clr = 1'b0;
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [15:0] d);
        wr_en = 1'b1; addr = a; wdata = d;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic rd(input logic [AW-1:0] a, output logic [15:0] d);
        rd_en = 1'b1; addr = a;
        @(negedge clk);
        rd_en = 1'b0;
        d = rdata;
    endtask

    function automatic logic [16:0] lfsr_after(input int n);
        logic [16:0] m = '0;
        for (int i = 0; i < n; i++) m = {m[15:0], ~(m[16] ^ m[11])};
        return m;
    endfunction

    task automatic test_reset();
        logic [15:0] d;
        clr = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (aud !== 1'b0) begin failures++;
            $display("FAIL reset_aud got=%b exp=0", aud); end
        checks++; if (active !== 4'h0) begin failures++;
            $display("FAIL reset_active got=%h exp=0", active); end
        checks++; if (done !== 4'h0) begin failures++;
            $display("FAIL reset_done got=%h exp=0", done); end
        checks++; if (rdata !== 16'h0) begin failures++;
            $display("FAIL reset_rdata got=%h exp=0", rdata); end
        clr = 1'b0;
        rd(5'd16, d);
        checks++; if (d !== 16'h0) begin failures++;
            $display("FAIL reset_random got=%h exp=0", d); end
    endtask

    task automatic test_regs();
        logic [15:0] d;
        do_reset();
        wr(5'd0, 16'h0ABC); rd(5'd0, d);
        checks++; if (d !== 16'h0ABC) begin failures++;
            $display("FAIL div_rb got=%h exp=0abc", d); end
        wr(5'd0, 16'hFFFF); rd(5'd0, d);
        checks++; if (d !== 16'h0FFF) begin failures++;
            $display("FAIL div_mask got=%h exp=0fff", d); end
        wr(5'd5, 16'h8745); rd(5'd5, d);
        checks++; if (d !== 16'h0705) begin failures++;
            $display("FAIL ctl_rb got=%h exp=0705", d); end
        wr(5'd10, 16'h1234); rd(5'd10, d);
        checks++; if (d !== 16'h1234) begin failures++;
            $display("FAIL dur_rb got=%h exp=1234", d); end
        wr(5'd20, 16'hFFFF); rd(5'd20, d);
        checks++; if (d !== 16'h0) begin failures++;
            $display("FAIL unmapped got=%h exp=0", d); end
        wr_en = 1'b1; rd_en = 1'b1; addr = 5'd10; wdata = 16'h5678;
        @(negedge clk);
        wr_en = 1'b0; rd_en = 1'b0;
        checks++; if (rdata !== 16'h1234) begin failures++;
            $display("FAIL rw_same_cycle got=%h exp=1234", rdata); end
        rd(5'd10, d);
        repeat (3) @(negedge clk);
        checks++; if (rdata !== 16'h5678) begin failures++;
            $display("FAIL rd_hold got=%h exp=5678", rdata); end
    endtask

    task automatic test_lfsr();
        logic [15:0] d;
        logic [16:0] m;
        int pts[3] = '{12, 200, 600};
        do_reset();
        for (int k = 0; k < 3; k++) begin
            while (cyc < pts[k]) @(negedge clk);
            m = lfsr_after(cyc / 4);
            rd(5'd16, d);
            checks++; if (d !== {8'd0, m[16:9]}) begin failures++;
                $display("FAIL random_%0d got=%h exp=%h", k, d, {8'd0, m[16:9]}); end
        end
    endtask

    task automatic test_tone();
        int edges[$];
        int bad_act = 0;
        logic prev = 1'b0;
        logic [3:0] v = '0;
        do_reset();
        wr(5'd0, 16'd2);
        wr(5'd1, 16'h800F);
        rd_en = 1'b1; addr = 5'd3;
        for (int i = 0; i < 120; i++) begin
            @(negedge clk);
            if (i > 0 && rdata[9] !== prev) edges.push_back(cyc);
            prev = rdata[9];
            v = rdata[3:0];
            if (rdata[8] !== 1'b1) bad_act++;
        end
        rd_en = 1'b0;
        checks++; if (edges.size() < 5) begin failures++;
            $display("FAIL tone_edges got=%0d exp>=5", edges.size()); end
        for (int k = 0; k < 4; k++) begin
            int gap;
            gap = (k + 1 < edges.size()) ? edges[k+1] - edges[k] : -1;
            checks++; if (gap != 12) begin failures++;
                $display("FAIL tone_half_period_%0d got=%0d exp=12", k, gap); end
        end
        checks++; if (bad_act != 0) begin failures++;
            $display("FAIL tone_active got=%0d_inactive exp=0", bad_act); end
        checks++; if (v !== 4'd15) begin failures++;
            $display("FAIL tone_vol got=%0d exp=15", v); end
    endtask

    task automatic test_envelope();
        int vols[$];
        int n_done = 0;
        int done_cyc = -1;
        do_reset();
        wr(5'd6, 16'd3);
        wr(5'd5, 16'h8405);
        rd_en = 1'b1; addr = 5'd7;
        while (cyc < 132) begin
            @(negedge clk);
            if (vols.size() == 0 || vols[$] != int'(rdata[3:0]))
                vols.push_back(int'(rdata[3:0]));
            if (done[1] === 1'b1) begin
                n_done++;
                if (done_cyc < 0) done_cyc = cyc;
            end
        end
        rd_en = 1'b0;
        checks++; if (vols.size() != 4) begin failures++;
            $display("FAIL env_steps got=%0d exp=4", vols.size()); end
        for (int k = 0; k < 4; k++) begin
            int g;
            g = (k < vols.size()) ? vols[k] : -1;
            checks++; if (g != 5 - k) begin failures++;
                $display("FAIL env_vol_%0d got=%0d exp=%0d", k, g, 5 - k); end
        end
        checks++; if (n_done != 1) begin failures++;
            $display("FAIL env_done_pulses got=%0d exp=1", n_done); end
        checks++; if (done_cyc != 96) begin failures++;
            $display("FAIL env_done_time got=%0d exp=96", done_cyc); end
        checks++; if (active[1] !== 1'b0) begin failures++;
            $display("FAIL env_active_end got=%b exp=0", active[1]); end
    endtask

    task automatic test_gate_collision();
        logic [15:0] d;
        do_reset();
        wr(5'd10, 16'd1);
        wr(5'd9, 16'h8407);
        while (cyc < 31) @(negedge clk);
        wr(5'd9, 16'h8409);
        checks++; if (done[2] !== 1'b0 || active[2] !== 1'b1) begin failures++;
            $display("FAIL collide_nodone got=done%b_act%b exp=done0_act1",
                     done[2], active[2]); end
        rd(5'd11, d);
        checks++; if (d !== 16'h0109) begin failures++;
            $display("FAIL collide_reload got=%h exp=0109", d); end
        while (done[2] !== 1'b1 && cyc < 120) @(negedge clk);
        checks++; if (cyc != 64) begin failures++;
            $display("FAIL collide_expire got=%0d exp=64", cyc); end
        rd(5'd11, d);
        checks++; if (d !== 16'h0008) begin failures++;
            $display("FAIL collide_after got=%h exp=0008", d); end
    endtask

    task automatic test_mixer();
        int hi;
        int expv[3] = '{18, 18, 7};
        do_reset();
        wr(5'd1, 16'h820F);
        wr(5'd5, 16'h8203);
        wr(5'd9, 16'h8305);
        for (int w = 0; w < 3; w++) begin
            if (w == 2) wr(5'd1, 16'h0204);
            repeat (4) @(negedge clk);
            hi = 0;
            for (int i = 0; i < 64; i++) begin
                if (aud === 1'b1) hi++;
                @(negedge clk);
            end
            checks++; if (hi != expv[w]) begin failures++;
                $display("FAIL mix_window_%0d got=%0d exp=%0d", w, hi, expv[w]); end
        end
        while (aud !== 1'b1 && cyc < 5000) @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        checks++; if (aud !== 1'b0 || active !== 4'h0) begin failures++;
            $display("FAIL clr_mid_note got=aud%b_act%h exp=aud0_act0", aud, active); end
        clr = 1'b0;
    endtask

    initial begin
        clr = 1'b1; wr_en = 1'b0; rd_en = 1'b0; addr = '0; wdata = '0;
        @(negedge clk);
        test_reset();
        test_regs();
        test_lfsr();
        test_tone();
        test_envelope();
        test_gate_collision();
        test_mixer();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/audio_synth_n.md
# audio_synth_n

Parametrised N-channel programmable sound generator, the next generation of the POKEY audio path. It adds wide per-channel dividers, a gated note mode with hardware duration and linear volume-decay envelope, and a parametrised channel count. It is driven by a simple synchronous register bus from the CPU-side bus adapter. It emits a single PWM audio bit summing all channels, the same way the existing mixer feeds the board audio pin.

## Interface
- NUM_CH, 4, number of channels (1..8)
- DIV_W, 12, divider register width (8..16)
- VOL_W, 4, volume width (1..8)
- PRESCALE, 56, clk cycles per base tick (≈1.79 MHz from 100 MHz; ≥2)
- FRAME_DIV, 1792, base ticks per frame tick (≈1 ms; ≥2)
- ADDR_W, derived, $clog2(4*NUM_CH+1)
- MIX_W, derived, VOL_W+$clog2(NUM_CH)
- clk  in  1  100 MHz system clock
- clr  in  1  synchronous active-high reset
- wr_en  in  1  register write strobe, one cycle
- rd_en  in  1  register read strobe, one cycle
- addr  in  ADDR_W  register address
- wdata  in  16  write data
- rdata  out  16  read data
- aud  out  1  PWM audio output
- active  out  NUM_CH  channel sounding (gated or continuous)
- done  out  NUM_CH  one-cycle pulse when a note's duration expires

## Operation
- Register map: channel c at base 4c: +0 DIV (DIV_W, rw), +1 CTL (rw), +2 DUR (16, rw), +3 STATUS (ro). Address 4*NUM_CH is RANDOM (ro). Unmapped reads return 0; unmapped writes are ignored.
- CTL fields: [VOL_W-1:0] volume; [9:8] mode (00 tone, 01 noise, 10 DC, 11 off); [10] env_en; [15] gate, write-only strobe that reads as 0.
- STATUS: [VOL_W-1:0] current volume; [8] active; [9] wave.
- Prescaler: counter 0..PRESCALE-1. tick is asserted in the cycle the counter equals PRESCALE-1.
- Frame counter: counts ticks 0..FRAME_DIV-1. frame is asserted when tick is asserted and the count equals FRAME_DIV-1.
- LFSR: 17 bits, shifts on tick, feedback ~(q[16]^q[11]), reset value 0. rand = q[16]. RANDOM reads q[16:9] zero-extended.
- Divider, per channel, counts ticks: on tick, if cnt >= DIV then cnt←0 and tone toggles; otherwise cnt+1. DIV=N gives a period of 2(N+1) ticks.
- Noise: sampled ← rand on each 0→1 transition of tone. wave = tone & sampled.
- wave by mode: tone → tone; noise → tone & sampled; DC → 1; off → 0.
- Gate: a CTL write with bit15=1 does the following:
  - active←1
  - cur_vol←CTL volume
  - dur_cnt←DUR
  - frame timing is not reset
- DUR=0 means continuous: the note never expires.
- A CTL write with gate=0 updates the fields only. If env_en=0, cur_vol tracks the CTL volume.
- On frame, for an active channel:
  - if env_en and cur_vol>0, cur_vol decrements by 1
  - if dur_cnt>0, it decrements by 1; when it goes 1→0, active←0 and done pulses that cycle
- Mixer: mix = Σ over channels with active & wave of cur_vol, width MIX_W.
- PWM: free-running MIX_W-bit counter pwm. aud = (pwm < mix).

## Timing
- Reset values: all registers, counters, LFSR, tone, sampled, cur_vol and pwm are 0; rdata=0, aud=0, active=0, done=0. clr mid-note silences aud the cycle after clr.
- Write latency: a register holds the new value in the cycle after wr_en. Gate effects (active, cur_vol, dur_cnt) are also visible in the cycle after wr_en.
- Read latency: rdata is valid the cycle after rd_en and holds until the next rd_en.
- wr_en and rd_en in the same cycle: both are performed. The read returns the pre-write value.
- Gate write in the same cycle as a frame that would expire the note: the gate wins. The note restarts and done does not pulse.
- DIV written below the current cnt: the divider wraps on the next tick (>= compare).
- DUR written while a note is active: the running dur_cnt is unaffected.
- aud changes only on the clk edge. The PWM period is 2^MIX_W clk cycles.

## Test plan
- Reset: assert clr for 2 cycles -> aud=0, active=0, rdata=0, and RANDOM reads 0 before the first tick.
- Tone period: PRESCALE=4, DIV0=2, CTL0 = gate, tone, vol=15, DUR=0 -> STATUS0.wave toggles every 12 clk (24-clk period); active stays 1 indefinitely.
- Duration and envelope: FRAME_DIV=8, PRESCALE=4, DUR=3, vol=5, env_en=1 -> cur_vol goes 5,4,3,2 at each frame; active drops and done pulses once at the third frame (96 clk ± frame phase).
- Gate collision: re-gate in exactly the cycle of the expiring frame -> no done pulse; cur_vol reloads and dur_cnt=DUR.
- Mixer: NUM_CH=4, two channels in DC mode with vol 15 and vol 3 -> mix=18; aud high for exactly 18 of every 64 clk.
- LFSR: after 3 ticks from reset, q[2:0]=3'b111 and RANDOM=0; run 131071 ticks -> the state returns to 0 (maximal length).
